axis_length_trim: RTL
=====================

# axis_length_trim

Streaming packet truncator that cuts every AXI-Stream packet longer than a programmed beat count. It forces `tlast` on the last allowed beat and silently discards the rest of the packet. Shorter or exact-length packets pass through unchanged. It sits directly downstream of the length-fill stage, so the pair fill-then-trim delivers packets of exactly `length` beats; it is also usable alone as a length limiter.

## Interface
- `DSIZE`, 32: data width in bits.
- `USIZE`, 1: `tuser` width in bits.
- `clock`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `length`  in  16  maximum beats per packet; sampled on the first beat of each packet; 0 is treated as 1.
- `axis_in_tvalid`  in  1  upstream valid.
- `axis_in_tready`  out  1  upstream ready.
- `axis_in_tdata`  in  DSIZE  upstream data.
- `axis_in_tuser`  in  USIZE  upstream user, passed per beat.
- `axis_in_tlast`  in  1  upstream end of packet.
- `axis_out_tvalid`  out  1  downstream valid, registered.
- `axis_out_tready`  in  1  downstream ready.
- `axis_out_tdata`  out  DSIZE  registered data.
- `axis_out_tuser`  out  USIZE  registered user.
- `axis_out_tlast`  out  1  registered end of packet (original or forced).
- `axis_out_tkeep`  out  DSIZE/8  constant all-ones.
- `trim_pulse`  out  1  one-cycle pulse when a forced-`tlast` beat is loaded into the output register.
- `trim_cnt`  out  16  count of truncated packets; saturates at 16'hFFFF.

## Operation
- The state machine has three states:
  - **IDLE**: waiting for the first beat of a packet.
  - **PASS**: inside a packet, forwarding beats.
  - **DROP**: discarding the excess of a truncated packet.
- Accept = `axis_in_tvalid && axis_in_tready`.
- `len_lat` (16 bit) loads `max(length,1)` on an accept in IDLE. It is held for the whole packet; changes to `length` mid-packet have no effect.
- `cnt` (16 bit) is the index of the accepted beat within the packet.
  - It is 0 for the first beat and increments on each forwarded accept.
  - It resets to 0 on any accept carrying input `tlast`, and on the forced-last beat.
  - It never exceeds `len_lat-1`, so there is no wrap.
- `limit` = (`cnt == len_lat-1`); in IDLE, `limit` is evaluated with `max(length,1)`.
- **IDLE / PASS**, on accept:
  - Load the output register with data, user and `tlast = axis_in_tlast || limit`.
  - If `axis_in_tlast`, go to IDLE.
  - Else if `limit`, go to DROP, assert `trim_pulse` and increment `trim_cnt`.
  - Else go to PASS.
- **DROP**:
  - `axis_in_tready = 1` unconditionally.
  - Accepted beats are discarded; output is not loaded.
  - An accept with `axis_in_tlast` goes to IDLE.
- A beat where input `tlast` and `limit` coincide is an exact-length packet:
  - Output `tlast = 1`.
  - It is not a truncation: no pulse, no count.
- Output register: full-throughput single stage.
  - `axis_in_tready = (state==DROP) || !axis_out_tvalid || axis_out_tready`.
  - `axis_out_tvalid` sets on load and clears on an output handshake without a simultaneous load.

## Timing
- Latency: 1 cycle from input accept to `axis_out_tvalid`. Throughput: 1 beat per cycle with `axis_out_tready` held high.
- `axis_out_*` are stable while `tvalid && !tready` (AXI-Stream rule).
- DROP always consumes 1 beat per cycle regardless of `axis_out_tready`.
  - The final held output beat (the forced-last beat) still waits for the downstream handshake.
- `trim_pulse` is high in the cycle after the forced-last accept, coincident with that beat first appearing on the output.
- Reset values: `axis_out_tvalid`, `axis_out_tlast`, `trim_pulse` are 0; `axis_out_tdata`, `axis_out_tuser` are 0; `trim_cnt` is 0; state is IDLE; `cnt` and `len_lat` are 0.
  - `axis_in_tready` is 1 in the first cycle after reset, since the output is empty.
- Reset mid-packet:
  - Any held output beat is lost.
  - The remaining upstream beats of that packet are treated as a new packet, counted from 0.
- `length` = 1: every packet is emitted as its first beat with `tlast = 1`; the remainder is dropped.

## Test plan
- `length`=4, 6-beat packet D0..D5, `axis_out_tready`=1 → out D0..D3 with `tlast` on D3; D4, D5 dropped; `trim_pulse` once; `trim_cnt`=1.
- `length`=4, 4-beat and 2-beat packets back-to-back → both unchanged, `tlast` on original last beats; no pulse; `trim_cnt`=0; no bubble between packets.
- `length`=0 and `length`=1, 3-beat packet → single beat D0 with `tlast`; `trim_cnt` increments each packet.
- `length`=3, 8-beat packet, random `axis_out_tready` at 50% → output D0..D2 intact and stable while stalled; drop phase ends on input `tlast`; the next packet starts at `cnt` 0.
- `length` changed from 4 to 2 on the third beat of a 6-beat packet → truncation still at 4 beats; the next packet uses 2.
- `rst` asserted during DROP, then a 2-beat packet with `length`=5 → all outputs return to reset values the next cycle; the new packet passes intact.

Source files
------------

// File: rtl/axis_length_trim_if.sv
// rtl/axis_length_trim_if.sv - AXI-Stream beat bundle shared by the trimmer's input and output ports.
interface axis_length_trim_if #(
  parameter int DSIZE = 32,
  parameter int USIZE = 1
);
  logic               tvalid;
  logic               tready;
  logic [DSIZE-1:0]   tdata;
  logic [USIZE-1:0]   tuser;
  logic               tlast;
  logic [DSIZE/8-1:0] tkeep;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    output tkeep,
    input  tready
  );

  // Upstream tkeep is not consumed: the trimmer regenerates an all-ones tkeep.
  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_length_trim.sv
// rtl/axis_length_trim.sv - truncates AXI-Stream packets to a programmed beat count,
// forcing tlast on the last allowed beat and discarding the excess.
module axis_length_trim #(
  parameter int DSIZE = 32,
  parameter int USIZE = 1
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [15:0]            length,
  axis_length_trim_if.slave      axis_in,
  axis_length_trim_if.master     axis_out,
  output logic                   trim_pulse,
  output logic [15:0]            trim_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [15:0]      len_lat_q;
  logic             out_valid_q;
  logic [DSIZE-1:0] out_data_q;
  logic [USIZE-1:0] out_user_q;
  logic             out_last_q;
  logic             trim_pulse_q;
  logic [15:0]      trim_cnt_q;

  logic [15:0] len_eff;
  logic [15:0] cur_len;
  logic        limit;
  logic        in_ready;
  logic        accept;

  // The first beat of a packet is judged against the live length input,
  // later beats against the value latched on that first beat.
  assign len_eff  = (length == 16'd0) ? 16'd1 : length;
  assign cur_len  = (state_q == IDLE) ? len_eff : len_lat_q;
  assign limit    = (cnt_q == (cur_len - 16'd1));
  assign in_ready = (state_q == DROP) || !out_valid_q || axis_out.tready;
  assign accept   = axis_in.tvalid && in_ready;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      len_lat_q    <= 16'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_last_q   <= 1'b0;
      trim_pulse_q <= 1'b0;
      trim_cnt_q   <= 16'd0;
    end else begin
      trim_pulse_q <= 1'b0;
      if (out_valid_q && axis_out.tready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE, PASS: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= axis_in.tdata;
            out_user_q  <= axis_in.tuser;
            out_last_q  <= axis_in.tlast || limit;
            if (state_q == IDLE) begin
              len_lat_q <= len_eff;
            end
            if (axis_in.tlast) begin
              state_q <= IDLE;
              cnt_q   <= 16'd0;
            end else if (limit) begin
              state_q      <= DROP;
              cnt_q        <= 16'd0;
              trim_pulse_q <= 1'b1;
              if (trim_cnt_q != 16'hFFFF) begin
                trim_cnt_q <= trim_cnt_q + 16'd1;
              end
            end else begin
              state_q <= PASS;
              cnt_q   <= cnt_q + 16'd1;
            end
          end
        end
        DROP: begin
          if (accept && axis_in.tlast) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 16'd0;
        end
      endcase
    end
  end

  assign axis_in.tready  = in_ready;
  assign axis_out.tvalid = out_valid_q;
  assign axis_out.tdata  = out_data_q;
  assign axis_out.tuser  = out_user_q;
  assign axis_out.tlast  = out_last_q;
  assign axis_out.tkeep  = '1;
  assign trim_pulse      = trim_pulse_q;
  assign trim_cnt        = trim_cnt_q;

endmodule
